// File: rtl/fb_pixel_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_pixel_writer : buffers TIA pixel strobes in a FIFO and drains them to |
// | the framebuffer over a req/ack write port.        Revision: 1.0          |
// +--------------------------------------------------------------------------+
module fb_pixel_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16,
  parameter int FB_PIXELS  = 76800
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          pix_wr_i,
  input  logic [DATA_WIDTH-1:0]         pix_dat_i,
  input  logic [ADDR_WIDTH-1:0]         pix_adr_i,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_adr_o,
  output logic [DATA_WIDTH-1:0]         mem_dat_o,
  input  logic                          mem_ack_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [15:0]                   drop_cnt_o,
  output logic                          frame_done_o,
  input  logic                          clr_stat_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FB_LIMIT = (ADDR_WIDTH+1)'(FB_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(FB_PIXELS - 1);
  localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ENT_W-1:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    overflow_q;
  logic [15:0]             drop_cnt_q;
  logic                    frame_done_q;

  logic                    in_range, full, empty, push, drop, pop;
  logic [ADDR_WIDTH-1:0]   head_adr;
  logic [DATA_WIDTH-1:0]   head_dat;

  assign in_range = ({1'b0, pix_adr_i} < FB_LIMIT);
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  // Fullness is judged on the pre-edge level, so a same-edge pop cannot rescue a pixel.
  assign push     = pix_wr_i && in_range && !full;
  assign drop     = pix_wr_i && in_range && full;
  assign {head_adr, head_dat} = fifo_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          if (!empty) pop     = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {pix_adr_i, pix_dat_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      frame_done_q <= (state_q == ST_BUSY) && mem_ack_i && (adr_q == LAST_ADR);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        adr_q    <= head_adr;
        dat_q    <= head_dat;
      end
    end
  end

  // A drop on the same edge as a clear restarts the count at one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_stat_i)                drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clr_stat_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign mem_req_o    = (state_q == ST_BUSY);
  assign mem_adr_o    = adr_q;
  assign mem_dat_o    = dat_q;
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire
